pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Parametrised next-generation PIC24 program counter.
- Holds the word-aligned instruction address (LSb fixed 0, MSb fixed 0) and supports increment, relative branch, two-word absolute load from the 16-bit databus, and call/return through an internal return-address stack.
- Sits between the control unit, which issues one-cycle command strobes, and the program-memory address port.

Parameters:
- PC_WIDTH, 23: byte-address width excluding the forced-0 MSb. Legal range 17..31. The internal register holds PC_WIDTH-1 word-index bits.
- DATA_WIDTH, 16: databus and branch-offset width.
- STACK_DEPTH, 4: return-stack entries, ≥1.
- RESET_VECTOR, 0: byte address loaded on reset. LSb ignored.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- pcinc_i  in  1  advance to next instruction.
- branch_i  in  1  relative branch.
- branch_off_i  in  DATA_WIDTH  signed word offset for branch.
- pcload_i  in  1  start absolute two-word load.
- call_i  in  1  push return address, then absolute two-word load.
- ret_i  in  1  pop return address into PC.
- databus_i  in  DATA_WIDTH  load data: LSW in the first cycle, MSW in the second.
- pc_addr_o  out  PC_WIDTH+1  {1'b0, pc_q, 1'b0}.
- busy_o  out  1  high while in StLoadHi; commands are ignored.
- stk_ovf_o  out  1  sticky: call issued with stack full.
- stk_unf_o  out  1  sticky: ret issued with stack empty.

Behaviour:
- Reset (synchronous, rst_i high at a rising edge):
  - pc_q = RESET_VECTOR[PC_WIDTH-1:1].
  - state = StIdle; stack pointer = 0; staging register cleared.
  - busy_o = 0, stk_ovf_o = 0, stk_unf_o = 0.
  - Reset overrides every command, including mid-load. A partial load is discarded and the PC is never partially updated.
- States (pc_state_e):
  - StIdle: accepts commands.
  - StLoadHi: waiting for the MSW.
- Command priority in StIdle when several strobes are high: pcload_i > call_i > ret_i > branch_i > pcinc_i. Lower-priority strobes in the same cycle are dropped.
- pcinc_i: pc_q <= pc_q + 1 (word index). Visible on pc_addr_o the next cycle. Wraps modulo 2^(PC_WIDTH-1), so default 7FFFFE -> 000000.
- branch_i: pc_q <= pc_q + 1 + sext(branch_off_i).
  - Computed in PC_WIDTH-1 bits, wraps modulo.
  - A negative offset of -1 leaves the PC unchanged (branch-to-self).
- pcload_i (cycle N):
  - Staging[14:0] <= databus_i[15:1]; state -> StLoadHi; busy_o = 1 in cycle N+1.
  - Cycle N+1: pc_q <= {databus_i[PC_WIDTH-17:0], staging[14:0]}; state -> StIdle.
  - New address appears in cycle N+2. pc_addr_o holds the old value throughout N and N+1.
  - Upper databus bits in the MSW are ignored.
- call_i (cycle N):
  - Push pc_q + 1 if the stack is not full.
  - Otherwise set stk_ovf_o and drop the push; the load still proceeds.
  - Then identical to pcload_i: LSW in N, MSW in N+1.
- ret_i:
  - If the stack is not empty: pop, pc_q <= top entry, next cycle.
  - If empty: set stk_unf_o; pc_q unchanged; stack pointer stays 0.
- In StLoadHi all strobes (pcinc_i, branch_i, pcload_i, call_i, ret_i) are ignored. The control unit must not rely on them.
- Sticky flags clear only on reset.
- Stack is LIFO:
  - Pointer range 0..STACK_DEPTH.
  - Full when pointer == STACK_DEPTH; empty when pointer == 0.
  - No simultaneous push and pop is possible, because call and ret are exclusive by priority.
- Default state-decode branch -> StIdle.

Decomposition:
- Package pic24_pkg:
  - pc_state_e {StIdle, StLoadHi}.
  - Constant PC_LSW_BITS = 15.
  - Function for sign-extending an offset to the PC word width.
- Sub-module pc_ret_stack:
  - Parametrised LIFO (WIDTH, DEPTH).
  - Ports: push, pop, din, dout, full, empty; synchronous active-high reset.
- The top level holds the FSM, the PC register and the staging register.

Test Plan:
- Reset, then 3× pcinc_i -> pc_addr_o 000000, 000002, 000004, 000006. Set pc_q to all-ones via load, then pcinc -> 7FFFFE -> 000000.
- pcload_i with LSW=16'h1234 then MSW=16'h0056 -> busy_o high one cycle; pc_addr_o holds old value for 2 cycles, then 561234. pcinc_i asserted during StLoadHi is ignored.
- From 000100:
  - branch_i with offset 16'h0010 -> 000122.
  - From 000100, offset 16'hFFFF -> 000100.
  - From 000000, offset 16'hFFFE -> 7FFFFE (wrap).
- Nested calls from 000200 to targets 001000, 002000 (two-word loads), then 2× ret_i -> 001002, then 000202. stk_unf_o stays 0.
- STACK_DEPTH=4: 5 calls -> stk_ovf_o set on the 5th and the 5th load still taken. 5 rets -> 4 valid pops, the 5th sets stk_unf_o with PC unchanged.
- rst_i asserted in StLoadHi after LSW=16'hFFFE -> pc_addr_o = RESET_VECTOR next cycle, busy_o=0, flags cleared, no partial load.
- Simultaneous pcload_i+pcinc_i+ret_i -> load only; stack pointer unchanged.

Source files
------------

// File: rtl/pic24_pkg.sv
// rtl/pic24_pkg.sv - shared types and helpers for the PIC24 program counter
package pic24_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StLoadHi
    } pc_state_e;

    localparam int PC_LSW_BITS = 15;

    // Sign-extend the low 'width' bits of off to 32 bits; callers truncate to the PC word width.
    function automatic logic [31:0] sext_off(input logic [31:0] off, input int unsigned width);
        logic signed [31:0] t;
        t = $signed(off << (32 - width));
        return $unsigned(t >>> (32 - width));
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// rtl/pc_ret_stack.sv - return-address LIFO for the program counter
module pc_ret_stack #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    assign full    = (ptr_q == PTR_W'(DEPTH));
    assign empty   = (ptr_q == '0);
    assign wr_idx  = IDX_W'(ptr_q);
    assign top_idx = IDX_W'(ptr_q - PTR_W'(1));
    // Top entry is meaningless while empty; the caller gates pops on empty.
    assign dout    = mem_q[top_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (push && !full) begin
            ptr_q <= ptr_q + PTR_W'(1);
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !full) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PIC24 program counter with two-word load and call/return stack
module pc_sequencer
    import pic24_pkg::*;
#(
    parameter int          PC_WIDTH     = 23,
    parameter int          DATA_WIDTH   = 16,
    parameter int          STACK_DEPTH  = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pcinc_i,
    input  logic                  branch_i,
    input  logic [DATA_WIDTH-1:0] branch_off_i,
    input  logic                  pcload_i,
    input  logic                  call_i,
    input  logic                  ret_i,
    input  logic [DATA_WIDTH-1:0] databus_i,
    output logic [PC_WIDTH:0]     pc_addr_o,
    output logic                  busy_o,
    output logic                  stk_ovf_o,
    output logic                  stk_unf_o
);

    localparam int WORD_W   = PC_WIDTH - 1;
    localparam int MSW_BITS = WORD_W - PC_LSW_BITS;

    pc_state_e                state_q;
    pc_state_e                state_d;
    logic [WORD_W-1:0]        pc_q;
    logic [WORD_W-1:0]        pc_inc;
    logic [WORD_W-1:0]        pc_branch;
    logic [WORD_W-1:0]        stk_dout;
    logic [PC_LSW_BITS-1:0]   stage_q;
    logic                     do_load;
    logic                     do_call;
    logic                     do_ret;
    logic                     do_branch;
    logic                     do_inc;
    logic                     stk_push;
    logic                     stk_pop;
    logic                     stk_full;
    logic                     stk_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StIdle;
        case (state_q)
            StIdle:   state_d = (pcload_i || call_i) ? StLoadHi : StIdle;
            StLoadHi: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Strobes are only honoured in StIdle, one per cycle in fixed priority order.
    always_comb begin
        busy_o    = 1'b0;
        do_load   = 1'b0;
        do_call   = 1'b0;
        do_ret    = 1'b0;
        do_branch = 1'b0;
        do_inc    = 1'b0;
        case (state_q)
            StIdle: begin
                do_load   = pcload_i;
                do_call   = !pcload_i && call_i;
                do_ret    = !pcload_i && !call_i && ret_i;
                do_branch = !pcload_i && !call_i && !ret_i && branch_i;
                do_inc    = !pcload_i && !call_i && !ret_i && !branch_i && pcinc_i;
            end
            StLoadHi: busy_o = 1'b1;
            default:  busy_o = 1'b0;
        endcase
    end

    assign pc_inc    = pc_q + WORD_W'(1);
    assign pc_branch = pc_inc + WORD_W'(sext_off(32'(branch_off_i), DATA_WIDTH));
    assign stk_push  = do_call && !stk_full;
    assign stk_pop   = do_ret && !stk_empty;
    assign pc_addr_o = {1'b0, pc_q, 1'b0};

    // The PC is only written once the MSW arrives, so a reset mid-load leaves no partial address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= RESET_VECTOR[PC_WIDTH-1:1];
            stage_q   <= '0;
            stk_ovf_o <= 1'b0;
            stk_unf_o <= 1'b0;
        end else begin
            if (state_q == StLoadHi) begin
                pc_q <= {databus_i[MSW_BITS-1:0], stage_q};
            end else if (do_load || do_call) begin
                stage_q <= databus_i[PC_LSW_BITS:1];
            end else if (stk_pop) begin
                pc_q <= stk_dout;
            end else if (do_branch) begin
                pc_q <= pc_branch;
            end else if (do_inc) begin
                pc_q <= pc_inc;
            end
            if (do_call && stk_full) begin
                stk_ovf_o <= 1'b1;
            end
            if (do_ret && stk_empty) begin
                stk_unf_o <= 1'b1;
            end
        end
    end

    pc_ret_stack #(
        .WIDTH (WORD_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

endmodule
